rgmii_rx_speed_adapt: RTL and testbench
=======================================

// Module: rgmii_rx_speed_adapt
// PURPOSE
//  Receive-side rate adapter between DDR-captured RGMII data and the GMII MAC, in the gmii_rx_clk domain.
//  At 1G it registers bytes straight through. At 10M/100M it assembles nibble pairs into bytes and emits
//  a clock-enable strobe, realigning nibble phase on the SFD. It also decodes and filters RGMII in-band status.
// PARAMETERS
//  INBAND_STATUS  "TRUE"  "TRUE": decode link/speed/duplex from rxd when idle; "FALSE": status outputs held at reset value
//  STATUS_FILTER  3       consecutive identical idle samples (1..15) required before status outputs update
//  SFD_REALIGN    "TRUE"  "TRUE": re-pair nibbles on a misaligned 5,D SFD; "FALSE": fixed pairing from frame start
// PORTS
//  clk            in   1  receive clock (gmii_rx_clk); all logic on rising edge
//  rst            in   1  asynchronous active-high reset
//  speed          in   2  2'b10 1G, 2'b01 100M, 2'b00 10M (2'b11 treated as 1G)
//  in_rxd         in   8  captured data; [3:0] rising-edge nibble, [7:4] falling-edge nibble
//  in_rx_dv       in   1  rising-edge RX_CTL
//  in_rx_er       in   1  RX_CTL rising XOR falling
//  gmii_rxd       out  8  assembled or registered byte
//  gmii_rx_dv     out  1  byte valid within frame (qualified by gmii_rx_clk_en)
//  gmii_rx_er     out  1  byte error (qualified by gmii_rx_clk_en)
//  gmii_rx_clk_en out  1  one-cycle strobe per output byte; constant 1 at 1G
//  rx_realign     out  1  one-cycle pulse when the SFD forced a nibble re-pairing
//  link_up        out  1  filtered in-band link status
//  link_speed     out  2  filtered in-band speed (same encoding as speed)
//  full_duplex    out  1  filtered in-band duplex
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE; sfd_seen=0; filter counter=0.
//  Mode latch: speed is sampled into mode_q only while the FSM is in IDLE. A speed change mid-frame takes effect after the frame ends.
//  1G mode (mode_q=2'b10):
//   - gmii_rxd/dv/er <= in_rxd/in_rx_dv/in_rx_er, 1-cycle latency; gmii_rx_clk_en=1 every cycle.
//  10M/100M mode: one nibble per cycle, taken from in_rxd[3:0]. The FSM has states IDLE, LOW, HIGH.
//   - IDLE, in_rx_dv=1: store nibble as low, go HIGH. sfd_seen=0.
//   - HIGH, in_rx_dv=1: emit {nibble,low} with er = er_low|in_rx_er, go LOW.
//   - LOW, in_rx_dv=1: store low, go HIGH.
//   - in_rx_dv=0 in LOW: go IDLE.
//   - in_rx_dv=0 in HIGH (odd nibble count): emit {4'h0,low} with dv=1, er=1; go IDLE.
//   - Emit: outputs registered; gmii_rx_clk_en=1 for exactly the cycle after the completing nibble, 0 otherwise.
//   - Between strobes gmii_rxd/dv/er hold their last value; dv drops with the first strobe after the frame.
//   - SFD realign (SFD_REALIGN="TRUE", sfd_seen=0):
//     - nibble 4'hD in state LOW with previous nibble 4'h5: emit 8'hD5 (er = er of the D nibble), pulse rx_realign, stay LOW, set sfd_seen.
//     - Aligned 5,D (D completes a byte in HIGH): set sfd_seen, no pulse.
//     - Once sfd_seen=1, no realign occurs until the next frame.
//  In-band status (INBAND_STATUS="TRUE"):
//   - Sample when in_rx_dv=0 and in_rx_er=0: link=rxd[0], speed=rxd[2:1], duplex=rxd[3].
//   - Counter increments while the sample equals the previous sample and resets to 1 on change; dv=1 or er=1 clears it to 0.
//   - When the counter reaches STATUS_FILTER, load link_up/link_speed/full_duplex (1 cycle later); the counter saturates.
//   - Status decoding is valid in all modes.
//  Async reset mid-frame: outputs clear immediately. After release the next in_rx_dv=1 is treated as a frame start.
// TESTING
//  1G: drive bytes 55,55,D5,12,34 with dv=1 -> identical bytes one cycle later, clk_en=1 every cycle.
//  100M aligned: nibbles 5 x15, D, 2,1,4,3 -> bytes 55 x7, D5, 12, 34 each with one clk_en pulse; rx_realign never asserted.
//  100M misaligned: 5 x14, D, 2,1 -> 55 x7, D5, 12; rx_realign pulses once, at the D5 strobe.
//  Odd end: frame ends after a lone nibble A -> final byte 0A with dv=1, er=1, then dv=0 at the next strobe.
//  In-band: idle rxd=4'hD for 3 cycles -> link_up=1, link_speed=2'b10, full_duplex=1; a 2-cycle glitch to 4'h0 produces no change.
//  Speed change 100M->1G mid-frame; rst asserted mid-frame -> mode is held until IDLE; reset clears all outputs within the same cycle.

Source files
------------

// File: rtl/rgmii_rx_speed_adapt.sv
// RGMII receive rate adapter: 1G byte pass-through, 10M/100M nibble-pair assembly with
// SFD nibble realignment, plus filtered decoding of RGMII in-band link status.
module rgmii_rx_speed_adapt #(
  parameter string INBAND_STATUS = "TRUE",
  parameter int    STATUS_FILTER = 3,
  parameter string SFD_REALIGN   = "TRUE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] in_rxd,
  input  logic       in_rx_dv,
  input  logic       in_rx_er,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_clk_en,
  output logic       rx_realign,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  localparam logic       INBAND_EN_C  = (INBAND_STATUS == "TRUE");
  localparam logic       REALIGN_EN_C = (SFD_REALIGN == "TRUE");
  localparam logic [3:0] FILT_C       = STATUS_FILTER[3:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      state_r;
  logic [1:0]  mode_r;
  logic [3:0]  low_r;
  logic        er_low_r;
  logic [3:0]  prev_nib_r;
  logic        sfd_seen_r;
  logic [3:0]  stat_cnt_r;
  logic [3:0]  stat_prev_r;

  logic [1:0]  speed_norm_s;
  logic [1:0]  mode_eff_s;
  logic [3:0]  nib_s;
  logic        stat_sample_s;

  // Between frames the live speed input governs; inside a frame the latched mode does.
  always_comb begin
    speed_norm_s  = (speed == 2'b11) ? 2'b10 : speed;
    mode_eff_s    = (state_r == ST_IDLE) ? speed_norm_s : mode_r;
    nib_s         = in_rxd[3:0];
    stat_sample_s = ~in_rx_dv & ~in_rx_er;
  end

  // Frame FSM, nibble pairing and registered GMII outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      mode_r         <= 2'b00;
      low_r          <= 4'h0;
      er_low_r       <= 1'b0;
      prev_nib_r     <= 4'h0;
      sfd_seen_r     <= 1'b0;
      gmii_rxd       <= 8'h00;
      gmii_rx_dv     <= 1'b0;
      gmii_rx_er     <= 1'b0;
      gmii_rx_clk_en <= 1'b0;
      rx_realign     <= 1'b0;
    end else begin
      rx_realign <= 1'b0;
      if (state_r == ST_IDLE) begin
        mode_r <= speed_norm_s;
      end else begin
        mode_r <= mode_r;
      end
      if (mode_eff_s == 2'b10) begin
        gmii_rxd       <= in_rxd;
        gmii_rx_dv     <= in_rx_dv;
        gmii_rx_er     <= in_rx_er;
        gmii_rx_clk_en <= 1'b1;
        sfd_seen_r     <= 1'b0;
        state_r        <= in_rx_dv ? ST_LOW : ST_IDLE;
      end else begin
        gmii_rx_clk_en <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (in_rx_dv) begin
              low_r      <= nib_s;
              er_low_r   <= in_rx_er;
              prev_nib_r <= nib_s;
              sfd_seen_r <= 1'b0;
              state_r    <= ST_HIGH;
            end else if (gmii_rx_dv) begin
              // closing strobe so the MAC sees dv fall after the last byte
              gmii_rx_dv     <= 1'b0;
              gmii_rx_er     <= 1'b0;
              gmii_rx_clk_en <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_HIGH: begin
            gmii_rx_clk_en <= 1'b1;
            gmii_rx_dv     <= 1'b1;
            if (in_rx_dv) begin
              gmii_rxd   <= {nib_s, low_r};
              gmii_rx_er <= er_low_r | in_rx_er;
              prev_nib_r <= nib_s;
              if ((nib_s == 4'hD) && (low_r == 4'h5)) begin
                sfd_seen_r <= 1'b1;
              end else begin
                sfd_seen_r <= sfd_seen_r;
              end
              state_r <= ST_LOW;
            end else begin
              gmii_rxd   <= {4'h0, low_r};
              gmii_rx_er <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end
          ST_LOW: begin
            if (!in_rx_dv) begin
              state_r <= ST_IDLE;
            end else if (REALIGN_EN_C && !sfd_seen_r && (nib_s == 4'hD) && (prev_nib_r == 4'h5)) begin
              // 5 then D landed across a byte boundary: emit the SFD and re-pair from here
              gmii_rxd       <= 8'hD5;
              gmii_rx_dv     <= 1'b1;
              gmii_rx_er     <= in_rx_er;
              gmii_rx_clk_en <= 1'b1;
              rx_realign     <= 1'b1;
              sfd_seen_r     <= 1'b1;
              prev_nib_r     <= nib_s;
              state_r        <= ST_LOW;
            end else begin
              low_r      <= nib_s;
              er_low_r   <= in_rx_er;
              prev_nib_r <= nib_s;
              state_r    <= ST_HIGH;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // In-band status: run-length filter over idle samples, outputs loaded once the run is long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt_r  <= 4'd0;
      stat_prev_r <= 4'h0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      full_duplex <= 1'b0;
    end else if (INBAND_EN_C) begin
      if (!stat_sample_s) begin
        stat_cnt_r <= 4'd0;
      end else if ((stat_cnt_r != 4'd0) && (nib_s == stat_prev_r)) begin
        stat_cnt_r <= (stat_cnt_r < FILT_C) ? stat_cnt_r + 4'd1 : stat_cnt_r;
      end else begin
        stat_cnt_r <= 4'd1;
      end
      if (stat_sample_s) begin
        stat_prev_r <= nib_s;
      end else begin
        stat_prev_r <= stat_prev_r;
      end
      if (stat_cnt_r == FILT_C) begin
        link_up     <= stat_prev_r[0];
        link_speed  <= stat_prev_r[2:1];
        full_duplex <= stat_prev_r[3];
      end else begin
        link_up     <= link_up;
        link_speed  <= link_speed;
        full_duplex <= full_duplex;
      end
    end else begin
      stat_cnt_r  <= 4'd0;
      stat_prev_r <= 4'h0;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_speed_adapt.sv
// Self-checking bench for rgmii_rx_speed_adapt: directed scenarios plus randomized frames
// compared cycle by cycle against a behavioural model of the adapter rules.
module tb_rgmii_rx_speed_adapt;
  localparam int FILT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] in_rxd;
  logic       in_rx_dv, in_rx_er;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, rx_realign;
  logic       link_up, full_duplex;
  logic [1:0] link_speed;
  logic [15:0] out_vec;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic       m_in_frame, m_pend, m_erl, m_sfd;
  logic [3:0] m_low, m_prev, m_last;
  logic [1:0] m_mode;
  int         m_run;
  logic [7:0] e_rxd;
  logic       e_dv, e_er, e_ce, e_ra, e_link, e_dup;
  logic [1:0] e_lspd;

  // directed-test observation
  logic [7:0] strobe_q[$];
  int         ra_cnt;
  logic [7:0] ra_byte;

  always #5 clk = ~clk;

  rgmii_rx_speed_adapt #(
    .INBAND_STATUS("TRUE"),
    .STATUS_FILTER(FILT),
    .SFD_REALIGN  ("TRUE")
  ) dut (
    .clk(clk), .rst(rst), .speed(speed), .in_rxd(in_rxd), .in_rx_dv(in_rx_dv), .in_rx_er(in_rx_er),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rx_clk_en(gmii_rx_clk_en), .rx_realign(rx_realign),
    .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex)
  );

  assign out_vec = {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, rx_realign, link_up, link_speed, full_duplex};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] norm(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  task automatic model_reset();
    m_in_frame = 1'b0; m_pend = 1'b0; m_erl = 1'b0; m_sfd = 1'b0;
    m_low = 4'h0; m_prev = 4'h0; m_last = 4'h0; m_mode = 2'b00; m_run = 0;
    e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_ce = 1'b0; e_ra = 1'b0;
    e_link = 1'b0; e_dup = 1'b0; e_lspd = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] s, input logic [7:0] d, input logic v, input logic e);
    logic [3:0] nib;
    nib = d[3:0];
    // status: publish the filtered value once the idle run has lasted FILT samples
    if (m_run >= FILT) begin
      e_link = m_last[0]; e_lspd = m_last[2:1]; e_dup = m_last[3];
    end
    if (v || e) m_run = 0;
    else begin
      if (m_run > 0 && nib == m_last) begin
        if (m_run < FILT) m_run++;
      end else m_run = 1;
      m_last = nib;
    end
    if (!m_in_frame) m_mode = norm(s);
    e_ra = 1'b0;
    if (m_mode == 2'b10) begin
      e_rxd = d; e_dv = v; e_er = e; e_ce = 1'b1;
      m_in_frame = v; m_pend = 1'b0;
    end else begin
      e_ce = 1'b0;
      if (v) begin
        if (!m_in_frame) begin
          m_in_frame = 1'b1; m_pend = 1'b1; m_low = nib; m_erl = e; m_sfd = 1'b0;
        end else if (m_pend) begin
          e_rxd = {nib, m_low}; e_dv = 1'b1; e_er = m_erl | e; e_ce = 1'b1;
          if (nib == 4'hD && m_low == 4'h5) m_sfd = 1'b1;
          m_pend = 1'b0;
        end else if (!m_sfd && nib == 4'hD && m_prev == 4'h5) begin
          e_rxd = 8'hD5; e_dv = 1'b1; e_er = e; e_ce = 1'b1; e_ra = 1'b1; m_sfd = 1'b1;
        end else begin
          m_pend = 1'b1; m_low = nib; m_erl = e;
        end
        m_prev = nib;
      end else if (m_in_frame) begin
        if (m_pend) begin
          e_rxd = {4'h0, m_low}; e_dv = 1'b1; e_er = 1'b1; e_ce = 1'b1;
        end
        m_in_frame = 1'b0; m_pend = 1'b0;
      end else if (e_dv) begin
        e_dv = 1'b0; e_er = 1'b0; e_ce = 1'b1;
      end
    end
  endtask

  // Called at posedge+1: apply inputs, advance one edge, compare against the model.
  task automatic cyc(input logic [1:0] s, input logic [7:0] d, input logic v, input logic e);
    speed = s; in_rxd = d; in_rx_dv = v; in_rx_er = e;
    @(posedge clk);
    model_step(s, d, v, e);
    #1;
    check_val("cycle", {16'h0, out_vec},
              {16'h0, e_rxd, e_dv, e_er, e_ce, e_ra, e_link, e_lspd, e_dup});
    if (gmii_rx_clk_en && gmii_rx_dv) strobe_q.push_back(gmii_rxd);
    if (rx_realign) begin
      ra_cnt++;
      ra_byte = gmii_rxd;
    end
  endtask

  task automatic nib_frame(input logic [1:0] s, input int n5, input int extra, input logic [3:0] tail[$]);
    for (int i = 0; i < n5; i++) cyc(s, 8'h05, 1'b1, 1'b0);
    if (extra > 0) cyc(s, 8'h0D, 1'b1, 1'b0);
    foreach (tail[i]) cyc(s, {4'h0, tail[i]}, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0]  g1[5];
    logic [3:0]  tl[$];
    logic [7:0]  exp_q[$];
    logic [1:0]  s;
    int          ce_cnt;
    g1[0] = 8'h55; g1[1] = 8'h55; g1[2] = 8'hD5; g1[3] = 8'h12; g1[4] = 8'h34;

    rst = 1'b1; speed = 2'b01; in_rxd = 8'h00; in_rx_dv = 1'b0; in_rx_er = 1'b0;
    model_reset();
    ra_cnt = 0; ra_byte = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check_val("reset_state", {16'h0, out_vec}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(2'b01, 8'h00, 1'b0, 1'b0);

    // 1G pass-through, one-cycle latency, clk_en every cycle
    for (int i = 0; i < 5; i++) begin
      cyc(2'b10, g1[i], 1'b1, 1'b0);
      check_val("g1_byte", {24'h0, gmii_rxd}, {24'h0, g1[i]});
      check_val("g1_clk_en", {31'h0, gmii_rx_clk_en}, 32'h1);
    end
    cyc(2'b10, 8'h00, 1'b0, 1'b0);
    check_val("g1_dv_end", {31'h0, gmii_rx_dv}, 32'h0);

    // 100M aligned preamble
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    strobe_q.delete(); ra_cnt = 0;
    tl = '{4'h2, 4'h1, 4'h4, 4'h3};
    nib_frame(2'b01, 15, 1, tl);
    for (int i = 0; i < 3; i++) cyc(2'b01, 8'h00, 1'b0, 1'b0);
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12, 8'h34};
    check_val("aligned_count", strobe_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < strobe_q.size()) check_val("aligned_byte", {24'h0, strobe_q[i]}, {24'h0, exp_q[i]});
    check_val("aligned_realign", ra_cnt, 0);

    // 100M misaligned preamble: one realign at the D5 strobe
    strobe_q.delete(); ra_cnt = 0; ra_byte = 8'h00;
    tl = '{4'h2, 4'h1};
    nib_frame(2'b01, 14, 1, tl);
    for (int i = 0; i < 3; i++) cyc(2'b01, 8'h00, 1'b0, 1'b0);
    exp_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12};
    check_val("misalign_count", strobe_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < strobe_q.size()) check_val("misalign_byte", {24'h0, strobe_q[i]}, {24'h0, exp_q[i]});
    check_val("misalign_realign", ra_cnt, 1);
    check_val("misalign_ra_byte", {24'h0, ra_byte}, 32'hD5);

    // odd nibble count: lone A becomes 0A with er, then dv drops on the next strobe
    cyc(2'b01, 8'h0A, 1'b1, 1'b0);
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    check_val("odd_byte", {20'h0, gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, rx_realign}, {20'h0, 8'h0A, 4'b1110});
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    check_val("odd_close", {29'h0, gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en}, 32'h1);

    // in-band status filter
    for (int i = 0; i < 4; i++) cyc(2'b01, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 8'h0D, 1'b0, 1'b0);
    check_val("status_not_yet", {31'h0, link_up}, 32'h0);
    cyc(2'b01, 8'h0D, 1'b0, 1'b0);
    check_val("status_loaded", {28'h0, link_up, link_speed, full_duplex}, 32'hD);
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    cyc(2'b01, 8'h0D, 1'b0, 1'b0);
    check_val("status_glitch", {28'h0, link_up, link_speed, full_duplex}, 32'hD);
    cyc(2'b01, 8'h0D, 1'b0, 1'b0);

    // speed change mid-frame: nibble assembly continues until the frame ends
    for (int i = 0; i < 3; i++) cyc(2'b01, 8'h05, 1'b1, 1'b0);
    ce_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(2'b10, 8'h07, 1'b1, 1'b0);
      if (gmii_rx_clk_en) ce_cnt++;
    end
    check_val("midframe_strobes", ce_cnt, 3);
    cyc(2'b10, 8'h00, 1'b0, 1'b0);
    cyc(2'b10, 8'h00, 1'b0, 1'b0);
    cyc(2'b10, 8'h00, 1'b0, 1'b0);
    check_val("after_switch_1g", {31'h0, gmii_rx_clk_en}, 32'h1);

    // async reset mid-frame clears outputs before the next edge
    for (int i = 0; i < 5; i++) cyc(2'b01, 8'h05, 1'b1, 1'b0);
    rst = 1'b1; speed = 2'b01; in_rxd = 8'h00; in_rx_dv = 1'b0; in_rx_er = 1'b0;
    #1;
    check_val("async_reset", {16'h0, out_vec}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    check_val("reset_held", {16'h0, out_vec}, 32'h0);
    rst = 1'b0;
    strobe_q.delete();
    cyc(2'b01, 8'h0A, 1'b1, 1'b0);
    cyc(2'b01, 8'h0B, 1'b1, 1'b0);
    cyc(2'b01, 8'h00, 1'b0, 1'b0);
    check_val("post_reset_count", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check_val("post_reset_byte", {24'h0, strobe_q[0]}, 32'hBA);

    // randomized frames across all speeds, with status idles, errors and speed changes
    for (int f = 0; f < 60; f++) begin
      logic [3:0] st;
      int         n;
      s  = 2'($urandom_range(0, 3));
      st = 4'($urandom_range(0, 15));
      n  = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) st = 4'($urandom_range(0, 15));
        cyc(s, {4'($urandom_range(0, 15)), st}, 1'b0, ($urandom_range(0, 9) == 0));
      end
      if (norm(s) == 2'b10) begin
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 11) == 0) s = 2'($urandom_range(0, 3));
          cyc(s, 8'($urandom), 1'b1, ($urandom_range(0, 15) == 0));
        end
      end else begin
        n = $urandom_range(12, 16);
        for (int i = 0; i < n + 1 + $urandom_range(0, 15); i++) begin
          logic [3:0] nb;
          if ($urandom_range(0, 11) == 0) s = 2'($urandom_range(0, 3));
          nb = (i < n) ? 4'h5 : (i == n) ? 4'hD : 4'($urandom_range(0, 15));
          cyc(s, {4'($urandom_range(0, 15)), nb}, 1'b1, ($urandom_range(0, 19) == 0));
        end
      end
    end
    for (int i = 0; i < 4; i++) cyc(2'b01, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
